c2c_master_burst_ctrl: RTL

- Next-generation chip-to-chip master controller.
- Performs a request/ack handshake with the slave, then shows a notice interval of programmable length.
- Transfers a burst of 1..BURST_MAX words of DATA_W bits, using a four-phase valid/ack handshake per word.
- Adds an ack timeout with bounded retry, an error report, and an internal notice timer (no external counter). Sits between the user button/switch logic and the inter-board pins.

---
 rtl/c2c_master_burst_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/c2c_master_burst_ctrl.sv
// Chip-to-chip burst master: request/ack handshake with bounded retry,
// a programmable notice interval, then a burst of 1..BURST_MAX words
// moved with a four-phase valid/ack handshake. All outputs are registered.
module c2c_master_burst_ctrl #(
    parameter int unsigned DATA_W      = 3,
    parameter int unsigned BURST_MAX   = 4,
    parameter int unsigned NOTICE_CYC  = 100000000,
    parameter int unsigned ACK_TIMEOUT = 50000000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned LEN_W       = $clog2(BURST_MAX + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          request,
    input  logic [LEN_W-1:0]              len,
    input  logic [BURST_MAX*DATA_W-1:0]   data_in,
    input  logic                          ack,
    output logic                          request2s,
    output logic                          notice,
    output logic [DATA_W-1:0]             data,
    output logic                          valid,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    // Shared timer covers both the notice interval and the ack timeouts.
    localparam int unsigned TMR_MAX = (NOTICE_CYC > ACK_TIMEOUT) ? NOTICE_CYC : ACK_TIMEOUT;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned IDX_W   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMR_W-1:0]   ACK_LAST    = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   NOTICE_LAST = TMR_W'(NOTICE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BACKOFF,
        NOTICE,
        SEND,
        GAP
    } state_t;

    state_t               state;
    logic [TMR_W-1:0]     timer;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     last_idx;
    logic [DATA_W-1:0]    words [BURST_MAX];
    logic [LEN_W-1:0]     len_clamp;

    // Requested length clamped to the payload capacity.
    always_comb begin
        len_clamp = len;
        if (len > LEN_W'(BURST_MAX)) begin
            len_clamp = LEN_W'(BURST_MAX);
        end
    end

    // Main controller: state, counters, payload capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            idx       <= '0;
            last_idx  <= '0;
            request2s <= 1'b0;
            notice    <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (request && (len != '0)) begin
                        for (int unsigned i = 0; i < BURST_MAX; i++) begin
                            words[i] <= data_in[i*DATA_W +: DATA_W];
                        end
                        last_idx  <= IDX_W'(len_clamp - 1'b1);
                        idx       <= '0;
                        timer     <= '0;
                        retry_cnt <= '0;
                        request2s <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (ack) begin
                        request2s <= 1'b0;
                        notice    <= 1'b1;
                        timer     <= '0;
                        state     <= NOTICE;
                    end else if (timer == ACK_LAST) begin
                        request2s <= 1'b0;
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= BACKOFF;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                BACKOFF: begin
                    if ((MAX_RETRY != 0) && (retry_cnt == RETRY_LIM)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        request2s <= 1'b1;
                        timer     <= '0;
                        state     <= REQ;
                    end
                end

                NOTICE: begin
                    if (!ack) begin
                        notice <= 1'b0;
                        error  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (timer == NOTICE_LAST) begin
                        notice <= 1'b0;
                        data   <= words[0];
                        valid  <= 1'b1;
                        state  <= SEND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                SEND: begin
                    if (!ack) begin
                        valid <= 1'b0;
                        data  <= '0;
                        if (idx == last_idx) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            timer <= '0;
                            state <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (ack) begin
                        data  <= words[idx];
                        valid <= 1'b1;
                        state <= SEND;
                    end else if (timer == ACK_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    request2s <= 1'b0;
                    notice    <= 1'b0;
                    data      <= '0;
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
